// File: rtl/csr_file_m_if.sv
// ============================================================================
// Module      : csr_file_m_if
// Description : Decoder/PC-select side bundle for the machine-mode CSR file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csr_file_m_if #(
    parameter int XLEN = 32
);
    logic [11:0]     csr_addr;
    logic [1:0]      csr_op;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic [XLEN-1:0] pc;
    logic            ecall;
    logic            mret;
    logic            retire;
    logic            redirect;
    logic [XLEN-1:0] trap_pc;

    modport master (
        output csr_addr, csr_op, csr_wdata, pc, ecall, mret, retire,
        input  csr_rdata, csr_illegal, redirect, trap_pc
    );

    modport slave (
        input  csr_addr, csr_op, csr_wdata, pc, ecall, mret, retire,
        output csr_rdata, csr_illegal, redirect, trap_pc
    );
endinterface

`default_nettype wire

// File: rtl/csr_file_m.sv
// ============================================================================
// Module      : csr_file_m
// Description : Parametrised M-mode CSR file with Zicsr ops, ecall/mret and counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_file_m #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
    parameter logic [XLEN-1:0] HART_ID      = '0,
    parameter bit              HAS_COUNTERS = 1'b1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    csr_file_m_if.slave    bus
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [1:0]      OP_NONE  = 2'b00;
    localparam logic [1:0]      OP_WRITE = 2'b01;
    localparam logic [1:0]      OP_SET   = 2'b10;
    localparam logic [XLEN-1:0] ALIGN4   = ~XLEN'(3);
    localparam logic [XLEN-1:0] CAUSE_ECALL_M = XLEN'(11);

    logic            mie;
    logic            mpie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mscratch;
    logic [63:0]     mcycle;
    logic [63:0]     minstret;

    logic            sel_mstatus, sel_mtvec, sel_mscratch, sel_mepc, sel_mcause;
    logic            sel_cyc_lo, sel_cyc_hi, sel_ret_lo, sel_ret_hi, sel_hartid;
    logic            is_counter, implemented, write_op, illegal, wr_en;
    logic [XLEN-1:0] mstatus_rd, old_val, new_val;

    always_comb begin
        sel_mstatus  = (bus.csr_addr == ADDR_MSTATUS);
        sel_mtvec    = (bus.csr_addr == ADDR_MTVEC);
        sel_mscratch = (bus.csr_addr == ADDR_MSCRATCH);
        sel_mepc     = (bus.csr_addr == ADDR_MEPC);
        sel_mcause   = (bus.csr_addr == ADDR_MCAUSE);
        sel_cyc_lo   = (bus.csr_addr == ADDR_MCYCLE);
        sel_ret_lo   = (bus.csr_addr == ADDR_MINSTRET);
        // High halves only exist when a counter does not fit in one register
        sel_cyc_hi   = (XLEN == 32) && (bus.csr_addr == ADDR_MCYCLEH);
        sel_ret_hi   = (XLEN == 32) && (bus.csr_addr == ADDR_MINSTRETH);
        sel_hartid   = (bus.csr_addr == ADDR_MHARTID);

        is_counter  = sel_cyc_lo | sel_cyc_hi | sel_ret_lo | sel_ret_hi;
        implemented = sel_mstatus | sel_mtvec | sel_mscratch | sel_mepc
                    | sel_mcause | is_counter | sel_hartid;
        write_op    = (bus.csr_op != OP_NONE);
        illegal     = !implemented
                    | (sel_hartid & write_op)
                    | (is_counter & !HAS_COUNTERS);
        wr_en       = write_op & !illegal & !bus.ecall & !bus.mret;

        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mpie;
        mstatus_rd[3]     = mie;

        old_val = '0;
        if (sel_mstatus)  old_val = mstatus_rd;
        if (sel_mtvec)    old_val = mtvec;
        if (sel_mscratch) old_val = mscratch;
        if (sel_mepc)     old_val = mepc;
        if (sel_mcause)   old_val = mcause;
        if (sel_cyc_lo)   old_val = mcycle[XLEN-1:0];
        if (sel_ret_lo)   old_val = minstret[XLEN-1:0];
        if (sel_cyc_hi)   old_val = XLEN'(mcycle[63:32]);
        if (sel_ret_hi)   old_val = XLEN'(minstret[63:32]);
        if (sel_hartid)   old_val = HART_ID;

        case (bus.csr_op)
            OP_WRITE: new_val = bus.csr_wdata;
            OP_SET:   new_val = old_val | bus.csr_wdata;
            default:  new_val = old_val & ~bus.csr_wdata;
        endcase
    end

    assign bus.csr_rdata   = illegal ? '0 : old_val;
    assign bus.csr_illegal = illegal;
    assign bus.redirect    = bus.ecall | bus.mret;
    assign bus.trap_pc     = bus.ecall ? mtvec : (bus.mret ? mepc : '0);

    // Trap entry beats return, and both beat an ordinary CSR write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= MTVEC_RESET & ALIGN4;
            mepc     <= '0;
            mcause   <= '0;
            mscratch <= '0;
        end else if (bus.ecall) begin
            mpie   <= mie;
            mie    <= 1'b0;
            mepc   <= bus.pc & ALIGN4;
            mcause <= CAUSE_ECALL_M;
        end else if (bus.mret) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (wr_en) begin
            if (sel_mstatus) begin
                mie  <= new_val[3];
                mpie <= new_val[7];
            end
            if (sel_mtvec)    mtvec    <= new_val & ALIGN4;
            if (sel_mscratch) mscratch <= new_val;
            if (sel_mepc)     mepc     <= new_val & ALIGN4;
            if (sel_mcause)   mcause   <= new_val;
        end
    end

    generate
        if (HAS_COUNTERS) begin : g_counters
            // A write to either half suppresses the increment of the full 64-bit counter
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mcycle   <= '0;
                    minstret <= '0;
                end else begin
                    if (wr_en && sel_cyc_lo)
                        mcycle <= (XLEN == 32) ? {mcycle[63:32], new_val[31:0]} : 64'(new_val);
                    else if (wr_en && sel_cyc_hi)
                        mcycle <= {new_val[31:0], mcycle[31:0]};
                    else
                        mcycle <= mcycle + 64'd1;

                    if (wr_en && sel_ret_lo)
                        minstret <= (XLEN == 32) ? {minstret[63:32], new_val[31:0]} : 64'(new_val);
                    else if (wr_en && sel_ret_hi)
                        minstret <= {new_val[31:0], minstret[31:0]};
                    else if (bus.retire)
                        minstret <= minstret + 64'd1;
                end
            end
        end else begin : g_no_counters
            assign mcycle   = '0;
            assign minstret = '0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_csr_file_m.sv
// ============================================================================
// Module      : tb_csr_file_m
// Description : Directed + randomised checks of csr_file_m against a spec-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_file_m;

    localparam logic [31:0] C_MTVEC_RESET = 32'h0000_1237;
    localparam logic [31:0] C_HART_ID     = 32'h0000_0005;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    csr_file_m_if #(.XLEN(32)) bus ();
    csr_file_m_if #(.XLEN(32)) bus2 ();

    csr_file_m #(
        .XLEN(32), .MTVEC_RESET(C_MTVEC_RESET), .HART_ID(C_HART_ID), .HAS_COUNTERS(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    csr_file_m #(
        .XLEN(32), .MTVEC_RESET(C_MTVEC_RESET), .HART_ID(C_HART_ID), .HAS_COUNTERS(1'b0)
    ) dut_nc (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural state as seen by software
    logic [31:0] m_ms, m_mtvec, m_mepc, m_mcause, m_mscratch;
    logic [63:0] m_cycle, m_instret;
    logic [31:0] last_rd, last_tp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ms       = 32'h0000_1800;
        m_mtvec    = C_MTVEC_RESET & 32'hFFFF_FFFC;
        m_mepc     = '0;
        m_mcause   = '0;
        m_mscratch = '0;
        m_cycle    = '0;
        m_instret  = '0;
    endtask

    task automatic model_read(input logic [11:0] a, output bit legal, output logic [31:0] v);
        legal = 1'b1;
        v     = '0;
        case (a)
            12'h300: v = m_ms;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'hB00: v = m_cycle[31:0];
            12'hB02: v = m_instret[31:0];
            12'hB80: v = m_cycle[63:32];
            12'hB82: v = m_instret[63:32];
            12'hF14: v = C_HART_ID;
            default: legal = 1'b0;
        endcase
    endtask

    task automatic model_edge(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                              input logic [31:0] p, input bit ec, input bit mr, input bit rt,
                              input bit ill, input logic [31:0] v);
        bit cyc_wr = 1'b0;
        bit ret_wr = 1'b0;
        logic [31:0] nv;
        if (ec) begin
            m_mepc   = p & 32'hFFFF_FFFC;
            m_mcause = 32'd11;
            m_ms     = 32'h1800 | ((m_ms & 32'h8) << 4);
        end else if (mr) begin
            m_ms = 32'h1880 | ((m_ms >> 4) & 32'h8);
        end else if (op != 2'b00 && !ill) begin
            nv = (op == 2'b01) ? wd : (op == 2'b10) ? (v | wd) : (v & ~wd);
            case (a)
                12'h300: m_ms       = 32'h1800 | (nv & 32'h88);
                12'h305: m_mtvec    = nv & 32'hFFFF_FFFC;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc     = nv & 32'hFFFF_FFFC;
                12'h342: m_mcause   = nv;
                12'hB00: begin m_cycle[31:0]    = nv; cyc_wr = 1'b1; end
                12'hB80: begin m_cycle[63:32]   = nv; cyc_wr = 1'b1; end
                12'hB02: begin m_instret[31:0]  = nv; ret_wr = 1'b1; end
                12'hB82: begin m_instret[63:32] = nv; ret_wr = 1'b1; end
                default: ;
            endcase
        end
        if (!cyc_wr) m_cycle = m_cycle + 64'd1;
        if (!ret_wr && rt) m_instret = m_instret + 64'd1;
    endtask

    // One clock cycle: drive, check combinational outputs mid-cycle, advance model at the edge
    task automatic step(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                        input logic [31:0] p, input bit ec, input bit mr, input bit rt);
        bit legal, ill;
        logic [31:0] v, tp;
        bus.csr_addr  = a;
        bus.csr_op    = op;
        bus.csr_wdata = wd;
        bus.pc        = p;
        bus.ecall     = ec;
        bus.mret      = mr;
        bus.retire    = rt;
        model_read(a, legal, v);
        ill = !legal || (a == 12'hF14 && op != 2'b00);
        tp  = ec ? m_mtvec : (mr ? m_mepc : 32'h0);
        #4;
        last_rd = bus.csr_rdata;
        last_tp = bus.trap_pc;
        chk($sformatf("rdata@%h", a), bus.csr_rdata, ill ? 32'h0 : v);
        chk($sformatf("illegal@%h", a), 32'(bus.csr_illegal), 32'(ill));
        chk("redirect", 32'(bus.redirect), 32'(ec | mr));
        chk("trap_pc", bus.trap_pc, tp);
        @(posedge clk);
        model_edge(a, op, wd, p, ec, mr, rt, ill, v);
        #1;
    endtask

    task automatic peek(input logic [11:0] a);
        bit legal;
        logic [31:0] v;
        bus.csr_addr = a;
        bus.csr_op   = 2'b00;
        bus.ecall    = 1'b0;
        bus.mret     = 1'b0;
        bus.retire   = 1'b0;
        model_read(a, legal, v);
        #1;
        chk($sformatf("rst_rdata@%h", a), bus.csr_rdata, v);
        chk("rst_illegal", 32'(bus.csr_illegal), 32'(!legal));
        chk("rst_redirect", 32'(bus.redirect), 32'h0);
    endtask

    logic [11:0] addr_pool [14] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02,
                                    12'hB80, 12'hB82, 12'hF14, 12'h7C0, 12'h301, 12'hB01, 12'h000};

    initial begin
        rst = 1'b1;
        bus.csr_addr = 12'h300; bus.csr_op = 2'b00; bus.csr_wdata = '0; bus.pc = '0;
        bus.ecall = 1'b0; bus.mret = 1'b0; bus.retire = 1'b0;
        bus2.csr_addr = 12'h300; bus2.csr_op = 2'b00; bus2.csr_wdata = '0; bus2.pc = '0;
        bus2.ecall = 1'b0; bus2.mret = 1'b0; bus2.retire = 1'b0;
        model_reset();
        #12;
        peek(12'h300);
        peek(12'h305);
        peek(12'hF14);
        @(negedge clk);
        rst = 1'b0;

        // Reset values and mhartid
        step(12'h300, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("mstatus_reset", last_rd, 32'h0000_1800);
        step(12'h305, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("mtvec_reset", last_rd, 32'h0000_1234);
        step(12'hF14, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // mtvec write then ecall
        step(12'h305, 2'b01, 32'h8000_0103, 32'h0, 1'b0, 1'b0, 1'b0);
        step(12'h300, 2'b00, 32'h0, 32'h8000_0040, 1'b1, 1'b0, 1'b0);
        chk("ecall_trap_pc", last_tp, 32'h8000_0100);
        step(12'h341, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("mepc_after_ecall", last_rd, 32'h8000_0040);
        step(12'h342, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // mstatus stacking
        step(12'h300, 2'b10, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0);
        step(12'h300, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("mstatus_set_mie", last_rd, 32'h0000_1808);
        step(12'h300, 2'b00, 32'h0, 32'h8000_0044, 1'b1, 1'b0, 1'b0);
        step(12'h300, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("mstatus_after_ecall", last_rd, 32'h0000_1880);
        step(12'h300, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("mret_trap_pc", last_tp, 32'h8000_0044);
        step(12'h300, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("mstatus_after_mret", last_rd, 32'h0000_1888);

        // mcycle carry into the high half
        step(12'hB00, 2'b01, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 1'b0);
        step(12'hB80, 2'b01, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(12'h300, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(12'h300, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(12'hB80, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("mcycleh_carry", last_rd, 32'h1);

        // minstret counts retirements
        step(12'hB02, 2'b01, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(12'h300, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(12'hB02, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("minstret_plus5", last_rd, 32'h5);

        // Illegal writes, then write dropped under ecall
        step(12'hF14, 2'b01, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b0);
        step(12'h7C0, 2'b01, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b0);
        step(12'h340, 2'b01, 32'hDEAD_BEEF, 32'h0000_2000, 1'b1, 1'b0, 1'b0);
        step(12'h340, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("mscratch_unchanged", last_rd, 32'h0);

        for (int i = 0; i < 400; i++) begin
            step(addr_pool[$urandom_range(0, 13)], 2'($urandom_range(0, 3)), $urandom, $urandom,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        model_reset();
        peek(12'h300);
        peek(12'h305);
        peek(12'h340);
        peek(12'h341);
        peek(12'h342);
        peek(12'hB00);
        peek(12'hB02);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(addr_pool[$urandom_range(0, 13)], 2'($urandom_range(0, 3)), $urandom, $urandom,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
        end

        // Instance without counters
        bus2.csr_addr = 12'hB00;
        #1;
        chk("nc_illegal_b00", 32'(bus2.csr_illegal), 32'h1);
        chk("nc_rdata_b00", bus2.csr_rdata, 32'h0);
        bus2.csr_addr = 12'hB82;
        #1;
        chk("nc_illegal_b82", 32'(bus2.csr_illegal), 32'h1);
        bus2.csr_addr = 12'h340;
        #1;
        chk("nc_legal_340", 32'(bus2.csr_illegal), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
